// File: rtl/ps2_pkg.sv
// Shared constants and frame FSM state type for the PS/2 scan-code receiver.
// Odd-parity checking is compiled in when PS2_PARITY_CHECK_EN is defined.
package ps2_pkg;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam int         PS2_FRAME_BITS   = 11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } ps2_state_t;
endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronises raw PS/2 clock/data into clk and emits a registered
// sample pulse on each falling edge of the synced PS/2 clock.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic sample
);
  logic [SYNC_STAGES-1:0] clk_sr;
  logic [SYNC_STAGES-1:0] dat_sr;
  logic                   clk_prev;

  // data_sync gets one extra flop so it lines up with the sample pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sr    <= '1;
      dat_sr    <= '1;
      clk_prev  <= 1'b1;
      data_sync <= 1'b1;
      sample    <= 1'b0;
    end else begin
      clk_sr    <= {clk_sr[SYNC_STAGES-2:0], ps2_clk};
      dat_sr    <= {dat_sr[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sr[SYNC_STAGES-1];
      data_sync <= dat_sr[SYNC_STAGES-1];
      sample    <= clk_prev & ~clk_sr[SYNC_STAGES-1];
    end
  end
endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard frame receiver with F0/E0 prefix stripping and watchdog.
// Define PS2_PARITY_CHECK_EN to drop frames with bad odd parity.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_flag,
  output logic       key_break,
  output logic       key_ext,
  output logic       frame_err
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  ps2_state_t      state, state_nxt;
  logic            data;
  logic            sample;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic [WD_W-1:0] wd;
  logic            break_pend;
  logic            ext_pend;
  logic            timeout;
  logic            par_ok;
  logic            is_brk;
  logic            is_ext;

  ps2_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .data_sync(data),
    .sample   (sample)
  );

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;
  assign par_ok = ^{shift, par_bit};
`else
  assign par_ok = 1'b1;
`endif

  // a sample in the expiry cycle wins over the watchdog
  assign timeout = (state != S_IDLE) && (wd == WD_MAX) && !sample;
  assign is_brk  = (shift == PS2_BREAK_PREFIX);
  assign is_ext  = (shift == PS2_EXT_PREFIX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = S_IDLE;
    end else if (sample) begin
      unique case (state)
        S_IDLE:   if (!data) state_nxt = S_DATA;
        S_DATA:   if (bit_cnt == 3'd7) state_nxt = S_PARITY;
        S_PARITY: state_nxt = S_STOP;
        S_STOP:   state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd <= '0;
    end else if (sample || state == S_IDLE) begin
      wd <= '0;
    end else if (wd != WD_MAX) begin
      wd <= wd + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt    <= '0;
      shift      <= '0;
      break_pend <= 1'b0;
      ext_pend   <= 1'b0;
      key_code   <= '0;
      key_flag   <= 1'b0;
      key_break  <= 1'b0;
      key_ext    <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      key_flag  <= 1'b0;
      frame_err <= 1'b0;
      if (timeout) begin
        bit_cnt    <= '0;
        shift      <= '0;
        break_pend <= 1'b0;
        ext_pend   <= 1'b0;
        frame_err  <= 1'b1;
      end else if (sample) begin
        unique case (state)
          S_IDLE: bit_cnt <= '0;
          S_DATA: begin
            shift   <= {data, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            par_bit <= data;
`endif
          end
          S_STOP: begin
            if (!data || !par_ok) begin
              frame_err <= 1'b1;
            end else begin
              unique case (1'b1)
                is_brk: break_pend <= 1'b1;
                is_ext: ext_pend <= 1'b1;
                default: begin
                  key_code   <= shift;
                  key_break  <= break_pend;
                  key_ext    <= ext_pend;
                  key_flag   <= 1'b1;
                  break_pend <= 1'b0;
                  ext_pend   <= 1'b0;
                end
              endcase
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: PS/2 frames in, strobes checked.
// Build with PS2_PARITY_CHECK_EN to exercise parity rejection.
module tb_ps2_scancode_rx;
  localparam int TO = 300;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_code;
  logic       key_flag;
  logic       key_break;
  logic       key_ext;
  logic       frame_err;

  typedef struct {
    logic       err;
    logic [7:0] code;
    logic       brk;
    logic       ext;
    logic       lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   fall_cyc = 0;
  logic prev_flag = 1'b0;

  ps2_scancode_rx #(
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_code (key_code),
    .key_flag (key_flag),
    .key_break(key_break),
    .key_ext  (key_ext),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_key(input logic [7:0] c, input logic b,
                          input logic e);
    exp_t x;
    x.err = 1'b0; x.code = c; x.brk = b; x.ext = e; x.lat = 1'b1;
    exp_q.push_back(x);
  endtask

  task automatic push_err(input logic lat);
    exp_t x;
    x.err = 1'b1; x.code = '0; x.brk = 1'b0; x.ext = 1'b0; x.lat = lat;
    exp_q.push_back(x);
  endtask

  task automatic ps2_bit(input logic b);
    @(posedge clk); #1 ps2_data = b;
    repeat (4) @(posedge clk);
    #1 ps2_clk = 1'b0;
    fall_cyc = cyc;
    repeat (8) @(posedge clk);
    #1 ps2_clk = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par,
                            input logic bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b ^ bad_par);
    ps2_bit(~bad_stop);
    #1 ps2_data = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  always @(negedge clk) begin
    if (rst && (key_flag || frame_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'd0, key_flag, frame_err}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event_kind", {31'd0, frame_err}, {31'd0, e.err});
        if (!e.err) begin
          check("key_code", {24'd0, key_code}, {24'd0, e.code});
          check("key_break", {31'd0, key_break}, {31'd0, e.brk});
          check("key_ext", {31'd0, key_ext}, {31'd0, e.ext});
          check("flag_gap", {31'd0, prev_flag}, 32'd0);
        end
        if (e.lat) check("latency", cyc - fall_cyc, 32'd4);
      end
    end
    prev_flag <= key_flag;
  end

  task automatic check_reset_outs(input string tag);
    @(negedge clk);
    check({tag, "_code"}, {24'd0, key_code}, 32'd0);
    check({tag, "_flag"}, {31'd0, key_flag}, 32'd0);
    check({tag, "_break"}, {31'd0, key_break}, 32'd0);
    check({tag, "_ext"}, {31'd0, key_ext}, 32'd0);
    check({tag, "_err"}, {31'd0, frame_err}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    check_reset_outs("rst0");
    @(posedge clk); #1 rst = 1'b1;
    repeat (10) @(posedge clk);

    push_key(8'h1D, 1'b0, 1'b0);
    send_frame(8'h1D, 1'b0, 1'b0);

    send_frame(8'hF0, 1'b0, 1'b0);
    push_key(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    push_key(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);

    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    push_key(8'h75, 1'b1, 1'b1);
    send_frame(8'h75, 1'b0, 1'b0);

`ifdef PS2_PARITY_CHECK_EN
    push_err(1'b1);
`else
    push_key(8'h23, 1'b0, 1'b0);
`endif
    send_frame(8'h23, 1'b1, 1'b0);

    push_err(1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);

    push_err(1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TO + 5) @(posedge clk);
    push_key(8'h44, 1'b0, 1'b0);
    send_frame(8'h44, 1'b0, 1'b0);

    send_frame(8'hF0, 1'b0, 1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    #1 rst = 1'b0;
    check_reset_outs("rst1");
    repeat (3) @(posedge clk);
    check_reset_outs("rst2");
    #1 ps2_data = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    push_key(8'h4B, 1'b0, 1'b0);
    send_frame(8'h4B, 1'b0, 1'b0);

    repeat (50) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

Receives raw PS/2 keyboard frames on `ps2_clk`/`ps2_data` and turns them into one-cycle scan-code events on the system clock. It strips the `F0` (break) and `E0` (extended) prefixes into flags. It sits directly upstream of `player_input`'s key watchers and supplies the code, strobe and make/break signals they consume.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages synchronising `ps2_clk` and `ps2_data` into `clk`; legal values ≥ 2.
- `TIMEOUT_CYCLES`, default 50000: number of `clk` cycles without a falling `ps2_clk` edge that aborts a partial frame (1 ms at 50 MHz).

- `clk`, input, 1: system clock. All logic runs in this single clock domain.
- `rst`, input, 1: reset, asynchronous, active-low.
- `ps2_clk`, input, 1: raw PS/2 clock, asynchronous to `clk`.
- `ps2_data`, input, 1: raw PS/2 data, asynchronous to `clk`.
- `key_code`, output, 8: last non-prefix scan code.
- `key_flag`, output, 1: one-cycle strobe; `key_code`, `key_break` and `key_ext` are valid in this cycle.
- `key_break`, output, 1: 1 means release (the code was preceded by `F0`); 0 means press.
- `key_ext`, output, 1: 1 means the code was preceded by `E0`.
- `frame_err`, output, 1: one-cycle strobe when a frame is dropped.

## Operation
- **Input conditioning:** both inputs pass through `SYNC_STAGES` flops. A falling edge of the synced clock (previous 1, current 0) is one `sample` pulse, and data is sampled on that pulse.
- **Frame FSM states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on `sample`, data 0 (start bit) moves to DATA with bit count 0. Data 1 is a glitch: stay in IDLE with no error.
  - DATA: shift data in LSB first, 8 samples, then move to PARITY.
  - PARITY: capture the parity bit, then move to STOP.
  - STOP: on `sample`, data 1 means the frame is complete; data 0 pulses `frame_err` and discards the frame. Either way, return to IDLE.
- **Parity check:** governed by `PS2_PARITY_CHECK_EN` (see Configuration).
- **Completed-frame decode:**
  - Byte `F0`: set `break_pending`. No strobe.
  - Byte `E0`: set `ext_pending`. No strobe.
  - Any other byte:
    - `key_code` takes the byte.
    - `key_break` takes `break_pending`.
    - `key_ext` takes `ext_pending`.
    - `key_flag` pulses high for one cycle.
    - Both pending bits clear.
- **Output hold:** `key_code`, `key_break` and `key_ext` hold their values until the next strobe.
- **Timeout:** a watchdog counter clears on every `sample` and counts only outside IDLE. When it reaches `TIMEOUT_CYCLES`:
  - the FSM returns to IDLE;
  - the shift register and both pending bits clear;
  - `frame_err` pulses.
- **Reset:** asserting `rst` aborts any frame in progress immediately. Reset values:
  - `key_code` = 8'h00;
  - `key_flag`, `key_break`, `key_ext`, `frame_err` = 0;
  - FSM in IDLE, pending bits 0, counters 0;
  - synchroniser flops at 1 (the bus idle level).

## Timing
- **Latency:** the `sample` pulse occurs `SYNC_STAGES`+1 `clk` cycles after the raw falling edge. `key_flag` and `frame_err` are registered and assert the cycle after the STOP-bit `sample`. Total: `SYNC_STAGES`+2 cycles from the raw falling edge of the stop bit; 4 cycles at default.
- **Strobe spacing:** `key_flag` is never high for two consecutive cycles. Strobes are spaced by at least one full 11-bit frame.
- **Simultaneous events:** if the timeout expires in the same cycle as a `sample`, the `sample` wins and the counter clears.
- **Parity error:** a `frame_err` caused by bad parity follows the same latency as `key_flag`.
- **Counter width:** the watchdog counter is $clog2(`TIMEOUT_CYCLES`+1) bits and saturates, so it never wraps.

## Configuration
- Macro: `PS2_PARITY_CHECK_EN`.
- **Defined:** at STOP, the XOR of the 8 data bits and the parity bit must be 1 (odd parity). On failure:
  - `frame_err` pulses;
  - no strobe is issued;
  - the pending bits are unchanged.
- **Undefined:** the parity bit is sampled and ignored, and parity never causes `frame_err`.

## Structure
- **Package `ps2_pkg`:**
  - `PS2_BREAK_PREFIX` = 8'hF0;
  - `PS2_EXT_PREFIX` = 8'hE0;
  - frame FSM state enum (IDLE/DATA/PARITY/STOP);
  - `PS2_FRAME_BITS` = 11.
- **Sub-module `ps2_sync_edge`:** one natural sub-module containing the parameterised synchroniser and falling-edge detector. It outputs the synced data and the `sample` pulse.
- **Top level:** the FSM, shift register, watchdog and prefix decode stay in `ps2_scancode_rx`.

## Test plan
- **Press W:** send frame 8'h1D with correct parity. Expect:
  - exactly one `key_flag` with `key_code`=1D, `key_break`=0, `key_ext`=0;
  - the strobe 4 cycles after the stop-bit edge.
- **Release A:** send `F0` then `1C`. Expect no strobe after `F0`, then one strobe with `key_code`=1C, `key_break`=1, `key_ext`=0. A subsequent `1C` gives `key_break`=0.
- **Extended release:** send `E0`, `F0`, `75`. Expect one strobe with `key_code`=75, `key_break`=1, `key_ext`=1.
- **Bad parity on frame 8'h23:**
  - macro defined: expect `frame_err` pulse and no `key_flag`;
  - macro undefined: expect `key_flag` with `key_code`=23.
- **Timeout:** send start plus 4 data bits, hold `ps2_clk` high for `TIMEOUT_CYCLES`+5 cycles, then a full `44` frame. Expect one `frame_err`, then a strobe with `key_code`=44.
- **Reset mid-frame:** send `F0`, then assert `rst` low during the data bits of the next frame. After release, send `4B`. Expect:
  - all outputs at reset values during reset;
  - then a strobe with `key_code`=4B and `key_break`=0, because the pending break is lost.
